// File: rtl/unary_stream_pkg.sv
// Shared types for the unary stream controller: FSM states, the output FIFO
// entry layout and the FIFO depth.
package unary_stream_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  localparam int FIFO_DEPTH = 2;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);

  // Wide enough for the count of the largest legal vector (W = 64).
  localparam int CNT_MAX_W = 6;

  typedef struct packed {
    logic [CNT_MAX_W-1:0] cnt;
    logic                 cmp;
  } entry_t;

endpackage

// File: rtl/unary_decode.sv
// Combinational admission check and unary count decode for one vector.
// Macro UNARY_STREAM_CTRL_COMPLIMENT_EN also admits complemented codes (MSB set).
module unary_decode #(
  parameter int W = 16
) (
  input  logic [W-1:0]         vec,
  output logic                 admit,
  output logic [$clog2(W)-1:0] cnt,
  output logic                 cmp
);

  localparam int CW = $clog2(W);

  logic [W-1:0] norm;

  // The MSB of an admitted normal form is zero, so W-1 bits never overflow CW.
  function automatic logic [CW-1:0] popcount(input logic [W-2:0] v);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < W - 1; i++) n = n + CW'(v[i]);
    return n;
  endfunction

  always_comb begin
    norm = vec;
    cmp  = 1'b0;
`ifdef UNARY_STREAM_CTRL_COMPLIMENT_EN
    if (vec[W-1]) begin
      norm = ~vec;
      cmp  = 1'b1;
    end
`endif
    // A run of low ones is exactly the set of values where v & (v+1) is zero.
    admit = !norm[W-1] && ((norm & (norm + W'(1))) == '0);
    cnt   = popcount(norm[W-2:0]);
  end

endmodule

// File: rtl/unary_stream_ctrl.sv
// Unary/thermometer vector admission with a 2-entry result FIFO, RUN/HALT
// error policy and saturating reject counter. Macro UNARY_STREAM_CTRL_COMPLIMENT_EN.
module unary_stream_ctrl
  import unary_stream_pkg::*;
#(
  parameter int W     = 16,
  parameter int ERR_W = 16
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic                 i_in_vld,
  input  logic [W-1:0]         i_in_dat,
  output logic                 o_in_rdy,
  output logic                 o_out_vld,
  output logic [$clog2(W)-1:0] o_out_cnt,
  output logic                 o_out_cmp,
  input  logic                 i_out_rdy,
  input  logic                 i_halt_on_err,
  input  logic                 i_clr,
  output logic                 o_halted,
  output logic [ERR_W-1:0]     o_err_cnt
);

  localparam int CW = $clog2(W);

  state_t           state, state_nxt;
  entry_t           mem [FIFO_DEPTH];
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [1:0]       count, count_nxt;
  logic             in_rdy;
  logic [ERR_W-1:0] err_cnt;

  logic          dec_admit;
  logic [CW-1:0] dec_cnt;
  logic          dec_cmp;
  logic          accept, push, reject, pop;

  // Entries carry the package-wide count width; narrow back to the port width.
  function automatic logic [CW-1:0] fit_cnt(input logic [CNT_MAX_W-1:0] c);
    if (c > CNT_MAX_W'((1 << CW) - 1)) return '1;
    return c[CW-1:0];
  endfunction

  unary_decode #(.W(W)) u_decode (
    .vec   (i_in_dat),
    .admit (dec_admit),
    .cnt   (dec_cnt),
    .cmp   (dec_cmp)
  );

  assign accept = i_in_vld & in_rdy & !i_clr;
  assign push   = accept & dec_admit;
  assign reject = accept & !dec_admit;
  assign pop    = (count != 2'd0) & i_out_rdy;

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    if (i_clr) begin
      state_nxt = RUN;
      count_nxt = '0;
    end else begin
      if (state == RUN && reject && i_halt_on_err) state_nxt = HALT;
      case ({push, pop})
        2'b10:   count_nxt = count + 2'd1;
        2'b01:   count_nxt = count - 2'd1;
        default: count_nxt = count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state   <= RUN;
      count   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      in_rdy  <= 1'b0;
      err_cnt <= '0;
    end else begin
      state  <= state_nxt;
      count  <= count_nxt;
      in_rdy <= (state_nxt == RUN) && (count_nxt < 2'(FIFO_DEPTH));
      if (i_clr) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        err_cnt <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (reject && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
      end
    end
  end

  // Payload storage carries no reset; outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{cnt: CNT_MAX_W'(dec_cnt), cmp: dec_cmp};
  end

  assign head      = mem[rd_ptr];
  assign o_out_vld = (count != 2'd0);
  assign o_out_cnt = o_out_vld ? fit_cnt(head.cnt) : '0;
  assign o_out_cmp = o_out_vld & head.cmp;
  assign o_in_rdy  = in_rdy;
  assign o_halted  = (state == HALT);
  assign o_err_cnt = err_cnt;

endmodule

// File: tb/tb_unary_stream_ctrl.sv
// Bench for unary_stream_ctrl (W=8, ERR_W=4): directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_unary_stream_ctrl;

  localparam int W     = 8;
  localparam int ERR_W = 4;

  logic             clk = 1'b0;
  logic             arst = 1'b1;
  logic             in_vld = 1'b0;
  logic [W-1:0]     in_dat = '0;
  logic             out_rdy = 1'b0;
  logic             halt_on_err = 1'b0;
  logic             clr = 1'b0;
  logic             in_rdy, out_vld, out_cmp, halted;
  logic [2:0]       out_cnt;
  logic [ERR_W-1:0] err_cnt;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  always #5 clk = ~clk;

  unary_stream_ctrl #(.W(W), .ERR_W(ERR_W)) dut (
    .clk           (clk),
    .arst          (arst),
    .i_in_vld      (in_vld),
    .i_in_dat      (in_dat),
    .o_in_rdy      (in_rdy),
    .o_out_vld     (out_vld),
    .o_out_cnt     (out_cnt),
    .o_out_cmp     (out_cmp),
    .i_out_rdy     (out_rdy),
    .i_halt_on_err (halt_on_err),
    .i_clr         (clr),
    .o_halted      (halted),
    .o_err_cnt     (err_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference decode: enumerate every legal code and look for a match.
  function automatic void ref_decode(input logic [W-1:0] v, output bit ok,
                                     output int n, output bit c);
    logic [W-1:0] nf;
    ok = 0; n = 0; c = 0;
    for (int k = 0; k < W; k++) begin
      nf = (W'(1) << k) - W'(1);
      if (v == nf) begin ok = 1; n = k; c = 0; end
`ifdef UNARY_STREAM_CTRL_COMPLIMENT_EN
      if (v == ~nf) begin ok = 1; n = k; c = 1; end
`endif
    end
  endfunction

  task automatic test_reset();
    arst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_cnt++; if (in_rdy !== 1'b0) $display("FAIL reset_in_rdy: got %0b expected 0", in_rdy); else pass_cnt++;
    chk_cnt++; if (out_vld !== 1'b0) $display("FAIL reset_out_vld: got %0b expected 0", out_vld); else pass_cnt++;
    chk_cnt++; if (out_cnt !== 3'd0) $display("FAIL reset_out_cnt: got %0d expected 0", out_cnt); else pass_cnt++;
    chk_cnt++; if (out_cmp !== 1'b0) $display("FAIL reset_out_cmp: got %0b expected 0", out_cmp); else pass_cnt++;
    chk_cnt++; if (halted !== 1'b0) $display("FAIL reset_halted: got %0b expected 0", halted); else pass_cnt++;
    chk_cnt++; if (err_cnt !== 4'd0) $display("FAIL reset_err_cnt: got %0d expected 0", err_cnt); else pass_cnt++;
    arst = 1'b0;
    step();
    chk_cnt++; if (in_rdy !== 1'b1) $display("FAIL reset_release_rdy: got %0b expected 1", in_rdy); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] vecs [3];
    logic [2:0]   exp  [3];
    vecs = '{8'h07, 8'h00, 8'h7F};
    exp  = '{3'd3, 3'd0, 3'd7};
    out_rdy = 1'b1;
    in_vld  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_dat = vecs[i];
      step();
      chk_cnt++; if (out_vld !== 1'b1) $display("FAIL b2b_vld%0d: got %0b expected 1", i, out_vld); else pass_cnt++;
      chk_cnt++; if (out_cnt !== exp[i]) $display("FAIL b2b_cnt%0d: got %0d expected %0d", i, out_cnt, exp[i]); else pass_cnt++;
      chk_cnt++; if (out_cmp !== 1'b0) $display("FAIL b2b_cmp%0d: got %0b expected 0", i, out_cmp); else pass_cnt++;
      chk_cnt++; if (in_rdy !== 1'b1) $display("FAIL b2b_rdy%0d: got %0b expected 1", i, in_rdy); else pass_cnt++;
    end
    in_vld = 1'b0;
    step();
    chk_cnt++; if (out_vld !== 1'b0) $display("FAIL b2b_drained: got %0b expected 0", out_vld); else pass_cnt++;
  endtask

  task automatic test_drop();
    halt_on_err = 1'b0;
    out_rdy = 1'b1;
    in_vld  = 1'b1;
    in_dat  = 8'h05;
    step();
    chk_cnt++; if (out_vld !== 1'b0) $display("FAIL drop_no_out: got %0b expected 0", out_vld); else pass_cnt++;
    chk_cnt++; if (err_cnt !== 4'd1) $display("FAIL drop_err: got %0d expected 1", err_cnt); else pass_cnt++;
    chk_cnt++; if (halted !== 1'b0) $display("FAIL drop_halted: got %0b expected 0", halted); else pass_cnt++;
    chk_cnt++; if (in_rdy !== 1'b1) $display("FAIL drop_rdy: got %0b expected 1", in_rdy); else pass_cnt++;
    in_dat = 8'h01;
    step();
    chk_cnt++; if (out_vld !== 1'b1) $display("FAIL drop_next_vld: got %0b expected 1", out_vld); else pass_cnt++;
    chk_cnt++; if (out_cnt !== 3'd1) $display("FAIL drop_next_cnt: got %0d expected 1", out_cnt); else pass_cnt++;
    in_vld = 1'b0;
    step();
  endtask

  task automatic test_halt();
    out_rdy = 1'b0;
    in_vld  = 1'b1;
    in_dat  = 8'h03;
    step();
    halt_on_err = 1'b1;
    in_dat = 8'h09;
    step();
    chk_cnt++; if (halted !== 1'b1) $display("FAIL halt_flag: got %0b expected 1", halted); else pass_cnt++;
    chk_cnt++; if (in_rdy !== 1'b0) $display("FAIL halt_rdy: got %0b expected 0", in_rdy); else pass_cnt++;
    chk_cnt++; if (err_cnt !== 4'd2) $display("FAIL halt_err: got %0d expected 2", err_cnt); else pass_cnt++;
    chk_cnt++; if (out_vld !== 1'b1) $display("FAIL halt_keep_vld: got %0b expected 1", out_vld); else pass_cnt++;
    chk_cnt++; if (out_cnt !== 3'd2) $display("FAIL halt_keep_cnt: got %0d expected 2", out_cnt); else pass_cnt++;
    in_dat  = 8'h01;
    out_rdy = 1'b1;
    step();
    chk_cnt++; if (out_vld !== 1'b0) $display("FAIL halt_drained: got %0b expected 0", out_vld); else pass_cnt++;
    step();
    chk_cnt++; if (out_vld !== 1'b0) $display("FAIL halt_no_accept: got %0b expected 0", out_vld); else pass_cnt++;
    chk_cnt++; if (halted !== 1'b1) $display("FAIL halt_sticky: got %0b expected 1", halted); else pass_cnt++;
    in_vld = 1'b0;
    clr    = 1'b1;
    step();
    clr = 1'b0;
    halt_on_err = 1'b0;
    chk_cnt++; if (halted !== 1'b0) $display("FAIL clr_halted: got %0b expected 0", halted); else pass_cnt++;
    chk_cnt++; if (err_cnt !== 4'd0) $display("FAIL clr_err: got %0d expected 0", err_cnt); else pass_cnt++;
    chk_cnt++; if (in_rdy !== 1'b1) $display("FAIL clr_rdy: got %0b expected 1", in_rdy); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    out_rdy = 1'b0;
    in_vld  = 1'b1;
    in_dat  = 8'h01;
    step();
    chk_cnt++; if (in_rdy !== 1'b1) $display("FAIL bp_rdy1: got %0b expected 1", in_rdy); else pass_cnt++;
    in_dat = 8'h03;
    step();
    chk_cnt++; if (in_rdy !== 1'b0) $display("FAIL bp_full_rdy: got %0b expected 0", in_rdy); else pass_cnt++;
    in_dat = 8'h07;
    step();
    chk_cnt++; if (out_cnt !== 3'd1) $display("FAIL bp_stable_cnt: got %0d expected 1", out_cnt); else pass_cnt++;
    chk_cnt++; if (in_rdy !== 1'b0) $display("FAIL bp_still_full: got %0b expected 0", in_rdy); else pass_cnt++;
    in_vld  = 1'b0;
    out_rdy = 1'b1;
    step();
    chk_cnt++; if (out_cnt !== 3'd2) $display("FAIL bp_second: got %0d expected 2", out_cnt); else pass_cnt++;
    chk_cnt++; if (out_vld !== 1'b1) $display("FAIL bp_second_vld: got %0b expected 1", out_vld); else pass_cnt++;
    step();
    chk_cnt++; if (out_vld !== 1'b0) $display("FAIL bp_only_two: got %0b expected 0", out_vld); else pass_cnt++;
  endtask

  task automatic test_compliment();
    clr = 1'b1;
    step();
    clr = 1'b0;
    out_rdy = 1'b1;
    in_vld  = 1'b1;
    in_dat  = 8'hF8;
    step();
`ifdef UNARY_STREAM_CTRL_COMPLIMENT_EN
    chk_cnt++; if (out_cnt !== 3'd3) $display("FAIL cmp_f8_cnt: got %0d expected 3", out_cnt); else pass_cnt++;
    chk_cnt++; if (out_cmp !== 1'b1) $display("FAIL cmp_f8_cmp: got %0b expected 1", out_cmp); else pass_cnt++;
`else
    chk_cnt++; if (out_vld !== 1'b0) $display("FAIL cmp_f8_rejected: got %0b expected 0", out_vld); else pass_cnt++;
    chk_cnt++; if (err_cnt !== 4'd1) $display("FAIL cmp_f8_err: got %0d expected 1", err_cnt); else pass_cnt++;
`endif
    in_dat = 8'hFF;
    step();
`ifdef UNARY_STREAM_CTRL_COMPLIMENT_EN
    chk_cnt++; if (out_cnt !== 3'd0) $display("FAIL cmp_ff_cnt: got %0d expected 0", out_cnt); else pass_cnt++;
    chk_cnt++; if (out_cmp !== 1'b1) $display("FAIL cmp_ff_cmp: got %0b expected 1", out_cmp); else pass_cnt++;
`else
    chk_cnt++; if (out_cmp !== 1'b0) $display("FAIL cmp_ff_tied: got %0b expected 0", out_cmp); else pass_cnt++;
    chk_cnt++; if (err_cnt !== 4'd2) $display("FAIL cmp_ff_err: got %0d expected 2", err_cnt); else pass_cnt++;
`endif
    in_vld = 1'b0;
    step();
  endtask

  task automatic test_err_saturate();
    clr = 1'b1;
    step();
    clr = 1'b0;
    halt_on_err = 1'b0;
    in_vld = 1'b1;
    in_dat = 8'h05;
    repeat (15) step();
    chk_cnt++; if (err_cnt !== 4'd15) $display("FAIL sat_reach: got %0d expected 15", err_cnt); else pass_cnt++;
    repeat (3) step();
    chk_cnt++; if (err_cnt !== 4'd15) $display("FAIL sat_hold: got %0d expected 15", err_cnt); else pass_cnt++;
    in_vld = 1'b0;
    step();
  endtask

  task automatic test_random();
    int  q_cnt [$];
    bit  q_cmp [$];
    int  m_err;
    bit  m_halted, m_rdy, ok, c;
    int  n, k;
    clr = 1'b1;
    step();
    clr = 1'b0;
    m_err = 0; m_halted = 0; m_rdy = 1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      chk_cnt++; if (in_rdy !== m_rdy) $display("FAIL rnd_rdy@%0d: got %0b expected %0b", cyc, in_rdy, m_rdy); else pass_cnt++;
      chk_cnt++; if (out_vld !== (q_cnt.size() != 0)) $display("FAIL rnd_vld@%0d: got %0b expected %0b", cyc, out_vld, q_cnt.size() != 0); else pass_cnt++;
      chk_cnt++; if (halted !== m_halted) $display("FAIL rnd_halted@%0d: got %0b expected %0b", cyc, halted, m_halted); else pass_cnt++;
      chk_cnt++; if (err_cnt !== 4'(m_err)) $display("FAIL rnd_err@%0d: got %0d expected %0d", cyc, err_cnt, m_err); else pass_cnt++;
      if (q_cnt.size() != 0) begin
        chk_cnt++; if (out_cnt !== 3'(q_cnt[0])) $display("FAIL rnd_cnt@%0d: got %0d expected %0d", cyc, out_cnt, q_cnt[0]); else pass_cnt++;
        chk_cnt++; if (out_cmp !== q_cmp[0]) $display("FAIL rnd_cmp@%0d: got %0b expected %0b", cyc, out_cmp, q_cmp[0]); else pass_cnt++;
      end
      k = $urandom_range(0, W - 1);
      case ($urandom_range(0, 2))
        0:       in_dat = (W'(1) << k) - W'(1);
        1:       in_dat = ~((W'(1) << k) - W'(1));
        default: in_dat = W'($urandom);
      endcase
      in_vld      = ($urandom_range(0, 3) != 0);
      out_rdy     = ($urandom_range(0, 3) != 0);
      halt_on_err = ($urandom_range(0, 7) == 0);
      clr         = ($urandom_range(0, 31) == 0);
      if (clr) begin
        q_cnt.delete(); q_cmp.delete();
        m_err = 0; m_halted = 0;
      end else begin
        if (q_cnt.size() != 0 && out_rdy) begin
          void'(q_cnt.pop_front()); void'(q_cmp.pop_front());
        end
        if (in_vld && m_rdy) begin
          ref_decode(in_dat, ok, n, c);
          if (ok) begin
            q_cnt.push_back(n); q_cmp.push_back(c);
          end else begin
            if (m_err < 15) m_err++;
            if (halt_on_err) m_halted = 1;
          end
        end
      end
      m_rdy = !m_halted && (q_cnt.size() < 2);
      step();
    end
    in_vld = 1'b0; clr = 1'b0; halt_on_err = 1'b0;
  endtask

  task automatic test_arst_mid();
    clr = 1'b1;
    step();
    clr = 1'b0;
    out_rdy = 1'b0;
    in_vld  = 1'b1;
    in_dat  = 8'h05;
    step();
    in_dat = 8'h03;
    step();
    in_dat = 8'h07;
    step();
    in_vld = 1'b0;
    chk_cnt++; if (out_vld !== 1'b1) $display("FAIL arst_pre_vld: got %0b expected 1", out_vld); else pass_cnt++;
    #1 arst = 1'b1;
    #1;
    chk_cnt++; if (out_vld !== 1'b0) $display("FAIL arst_vld: got %0b expected 0", out_vld); else pass_cnt++;
    chk_cnt++; if (out_cnt !== 3'd0) $display("FAIL arst_cnt: got %0d expected 0", out_cnt); else pass_cnt++;
    chk_cnt++; if (err_cnt !== 4'd0) $display("FAIL arst_err: got %0d expected 0", err_cnt); else pass_cnt++;
    chk_cnt++; if (in_rdy !== 1'b0) $display("FAIL arst_rdy: got %0b expected 0", in_rdy); else pass_cnt++;
    chk_cnt++; if (halted !== 1'b0) $display("FAIL arst_halted: got %0b expected 0", halted); else pass_cnt++;
    step();
    arst = 1'b0;
    step();
    chk_cnt++; if (in_rdy !== 1'b1) $display("FAIL arst_release_rdy: got %0b expected 1", in_rdy); else pass_cnt++;
    chk_cnt++; if (out_vld !== 1'b0) $display("FAIL arst_discarded: got %0b expected 0", out_vld); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_drop();
    test_halt();
    test_backpressure();
    test_compliment();
    test_err_saturate();
    test_random();
    test_arst_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/unary_stream_ctrl.md
UNARY_STREAM_CTRL -- requirements
Module: unary_stream_ctrl

Interface
REQ-001 SHALL have parameter W, default 16: bit-width of each input vector; legal range 2..64.
REQ-002 SHALL have parameter ERR_W, default 16: width of the saturating error counter.
REQ-003 SHALL have port clk  input  1: sole clock; all state is updated on its rising edge.
REQ-004 SHALL have port arst  input  1: asynchronous, active-high reset.
REQ-005 SHALL have port i_in_vld  input  1: input vector valid.
REQ-006 SHALL have port i_in_dat  input  W: candidate unary/thermometer vector.
REQ-007 SHALL have port o_in_rdy  output  1: the block can accept an input vector.
REQ-008 SHALL have port o_out_vld  output  1: output result valid.
REQ-009 SHALL have port o_out_cnt  output  $clog2(W): decoded unary count.
REQ-010 SHALL have port o_out_cmp  output  1: the result came from a complimented code.
REQ-011 SHALL have port i_out_rdy  input  1: the consumer accepts the output result.
REQ-012 SHALL have port i_halt_on_err  input  1: policy select; 1 = halt on a rejected vector, 0 = drop and continue.
REQ-013 SHALL have port i_clr  input  1: synchronous clear of queue, FSM and error counter.
REQ-014 SHALL have port o_halted  output  1: the FSM is in the HALT state.
REQ-015 SHALL have port o_err_cnt  output  ERR_W: number of rejected vectors, saturating.

Function
REQ-016 SHALL accept an input vector on a cycle with i_in_vld & o_in_rdy & !i_clr.
REQ-017 SHALL admit the normal form: k least-significant ones, all other bits zero, with k in 0..W-1; the all-zeros vector is admitted with count 0.
REQ-018 SHALL, when the compliment feature is compiled in and the vector MSB is 1, admit only the bitwise compliment of a normal-form vector; count = number of zeros; o_out_cmp = 1; the all-ones vector is admitted with count 0.
REQ-019 SHALL reject every other vector, including all-ones when the compliment feature is compiled out.
REQ-020 SHALL push each admitted result {cnt, cmp} into a 2-entry output FIFO, visible on o_out_* on the cycle after acceptance (latency 1).
REQ-021 SHALL hold o_out_vld = FIFO non-empty, drive o_out_* from the FIFO head, and pop the FIFO on o_out_vld & i_out_rdy.
REQ-022 SHALL keep o_out_cnt and o_out_cmp stable while o_out_vld & !i_out_rdy.
REQ-023 SHALL drive o_in_rdy from a flop: o_in_rdy = (state == RUN) & (FIFO has a free entry after this cycle's push/pop).
REQ-024 SHALL sustain one vector per cycle when i_out_rdy is held high.
REQ-025 SHALL implement a two-state FSM: RUN and HALT.
- RUN -> HALT: a rejected vector is accepted while i_halt_on_err = 1.
- HALT -> RUN: only on i_clr.
REQ-026 SHALL drop a rejected vector without pushing it to the FIFO and increment o_err_cnt, saturating at 2^ERR_W-1, in both RUN and HALT policy.
REQ-027 SHALL, while in HALT, hold o_in_rdy = 0 and keep draining existing FIFO entries to the consumer.
REQ-028 SHALL, on i_clr, empty the FIFO, zero o_err_cnt and enter RUN in the same edge; any input presented that cycle is not accepted and not counted.
REQ-029 SHALL, when a pop and a push coincide with the FIFO full, complete both and keep the FIFO full.
REQ-030 SHALL drive o_halted = (state == HALT).

Reset
REQ-031 SHALL, on arst, force state = RUN, FIFO empty, o_out_vld = 0, o_out_cnt = 0, o_out_cmp = 0, o_err_cnt = 0, o_halted = 0, o_in_rdy = 0.
REQ-032 SHALL raise o_in_rdy to 1 on the first clock edge after arst deasserts; reset asserted mid-transfer discards all queued results.

Configuration
REQ-033 SHALL use macro UNARY_STREAM_CTRL_COMPLIMENT_EN to compile in the compliment admission of REQ-018.
REQ-034 SHALL, with the macro undefined, tie o_out_cmp to 0 and apply the REQ-019 rejection to any vector with the MSB set.

Structure
REQ-035 SHALL place the FSM state enum (RUN, HALT), the FIFO entry struct {cnt, cmp} and the FIFO depth constant (2) in package unary_stream_pkg.
REQ-036 SHALL implement admission and count decode in one combinational sub-module, unary_decode (vector in; admit, cnt, cmp out); FIFO, FSM and counter live in the top module.

Verification (W=8)
REQ-037 SHALL check: input 0x07, 0x00, 0x7F back-to-back with i_out_rdy=1 -> outputs cnt 3, 0, 7 on consecutive cycles, each one cycle after its input, o_in_rdy held at 1.
REQ-038 SHALL check: input 0x05 with i_halt_on_err=0 -> no output, o_err_cnt=1, next vector 0x01 -> cnt 1.
REQ-039 SHALL check: 0x03 queued, then 0x09 with i_halt_on_err=1 -> o_halted=1 and o_in_rdy=0 next cycle, 0x03 result still delivered; i_clr -> o_halted=0, o_err_cnt=0.
REQ-040 SHALL check: i_out_rdy=0 while 3 vectors are offered -> exactly 2 accepted, o_in_rdy=0, outputs stable; i_out_rdy=1 -> both drained in order.
REQ-041 SHALL check, with the macro: 0xF8 -> cnt 3, cmp 1; 0xFF -> cnt 0, cmp 1. Without the macro: 0xF8 -> rejected, o_err_cnt increments.
REQ-042 SHALL check: arst asserted with 2 FIFO entries -> o_out_vld=0 immediately and all REQ-031 values hold.
